// File: rtl/datapath.sv
// Single-cycle MIPS-style datapath.
// Holds the PC and a 32 x n register file. Operand selection, the ALU,
// write-back selection and next-PC selection are combinational. All
// control comes from an external controller, and both memories are external.
module datapath #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memtoreg,
    input  logic         pcsrc,
    input  logic         alusrc,
    input  logic         regdst,
    input  logic         regwrite,
    input  logic         jump,
    input  logic [2:0]   alucontrol,
    output logic         zero,
    output logic [n-1:0] pc,
    input  logic [n-1:0] instr,
    output logic [n-1:0] aluout,
    output logic [n-1:0] writedata,
    input  logic [n-1:0] readdata
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [n-1:0] r_pc;
    logic [n-1:0] r_rf [0:31];

    logic [4:0]   w_rs;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [15:0]  w_imm;
    logic [n-1:0] w_signimm;
    logic [n-1:0] w_rd1;
    logic [n-1:0] w_rd2;
    logic [n-1:0] w_srcb;
    logic [n-1:0] w_alu;
    logic [n-1:0] w_result;
    logic [4:0]   w_waddr;
    logic [n-1:0] w_pcplus4;
    logic [n-1:0] w_pcbranch;
    logic [n-1:0] w_pcnextbr;
    logic [n-1:0] w_pcjump;
    logic [n-1:0] w_pcnext;

    // The opcode and funct fields are decoded by the controller, not here.
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr[31:26];

    // Split the instruction into its fields and sign-extend the immediate.
    always_comb begin
        w_rs      = instr[25:21];
        w_rt      = instr[20:16];
        w_rd      = instr[15:11];
        w_imm     = instr[15:0];
        w_signimm = {{(n-16){w_imm[15]}}, w_imm};
    end

    // Register file read ports. Register 0 is hard-wired to zero.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs != 5'd0) begin
            w_rd1 = r_rf[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_rd2 = r_rf[w_rt];
        end
    end

    // ALU operand B select.
    always_comb begin
        w_srcb = alusrc ? w_signimm : w_rd2;
    end

    // ALU. The unused encodings produce zero. Add and subtract wrap.
    always_comb begin
        w_alu = '0;
        case (alucontrol)
            ALU_AND: w_alu = w_rd1 & w_srcb;
            ALU_OR:  w_alu = w_rd1 | w_srcb;
            ALU_ADD: w_alu = w_rd1 + w_srcb;
            ALU_SUB: w_alu = w_rd1 - w_srcb;
            ALU_SLT: w_alu = ($signed(w_rd1) < $signed(w_srcb)) ? {{(n-1){1'b0}}, 1'b1} : '0;
            default: w_alu = '0;
        endcase
    end

    // Write-back data and destination register select.
    always_comb begin
        w_result = memtoreg ? readdata : w_alu;
        w_waddr  = regdst ? w_rd : w_rt;
    end

    // Next-PC select. A jump overrides both the branch and the sequential path.
    always_comb begin
        w_pcplus4  = r_pc + n'(4);
        w_pcbranch = w_pcplus4 + {w_signimm[n-3:0], 2'b00};
        w_pcnextbr = pcsrc ? w_pcbranch : w_pcplus4;
        w_pcjump   = {w_pcplus4[n-1:n-4], instr[25:0], 2'b00};
        w_pcnext   = jump ? w_pcjump : w_pcnextbr;
    end

    // PC register. Reset returns it to address zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pcnext;
        end
    end

    // Register file write port. Reset clears every entry and discards any
    // write in that cycle. Writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (regwrite && (w_waddr != 5'd0)) begin
            r_rf[w_waddr] <= w_result;
        end
    end

    // Drive the outputs from the current state and the instruction.
    always_comb begin
        pc        = r_pc;
        aluout    = w_alu;
        zero      = (w_alu == '0);
        writedata = w_rd2;
    end

endmodule

// File: tb/tb_datapath.sv
// Testbench for datapath. A behavioural model tracks the PC and the
// registers. A compare process checks every cycle against that model.
// Directed steps check literal values, and a random run follows them.
module tb_datapath;

    logic        clk;
    logic        reset;
    logic        memtoreg;
    logic        pcsrc;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        jump;
    logic [2:0]  alucontrol;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    bit          chk_en = 0;

    datapath #(.n(32)) dut (
        .clk(clk), .reset(reset), .memtoreg(memtoreg), .pcsrc(pcsrc),
        .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .jump(jump),
        .alucontrol(alucontrol), .zero(zero), .pc(pc), .instr(instr),
        .aluout(aluout), .writedata(writedata), .readdata(readdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        return (a == 0) ? 32'd0 : m_rf[a];
    endfunction

    function automatic logic [31:0] m_sext(input logic [31:0] ins);
        return {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic [31:0] m_alu_out();
        logic [31:0] a, b;
        a = m_reg(instr[25:21]);
        b = alusrc ? m_sext(instr) : m_reg(instr[20:16]);
        case (alucontrol)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        logic [31:0] res, nxt;
        logic [4:0]  wa;
        if (reset) begin
            m_pc = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
        end else begin
            res = memtoreg ? readdata : m_alu_out();
            wa  = regdst ? instr[15:11] : instr[20:16];
            if (jump)       nxt = {m_pc[31:28] + 4'd0, instr[25:0], 2'b00};
            else if (pcsrc) nxt = m_pc + 4 + (m_sext(instr) * 4);
            else            nxt = m_pc + 4;
            if (jump) nxt[31:28] = m_pc_plus4_top(m_pc);
            if (regwrite && wa != 0) m_rf[wa] = res;
            m_pc = nxt;
        end
        chk_en = 1;
    end

    function automatic logic [3:0] m_pc_plus4_top(input logic [31:0] p);
        logic [31:0] q;
        q = p + 4;
        return q[31:28];
    endfunction

    // Compare process: checks all outputs against the model at each falling edge.
    always @(negedge clk) begin
        logic [31:0] y;
        if (chk_en) begin
            y = m_alu_out();
            check("pc", pc, m_pc);
            check("aluout", aluout, y);
            check("zero", {31'd0, zero}, {31'd0, (y == 0)});
            check("writedata", writedata, m_reg(instr[20:16]));
        end
    end

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    // Apply one cycle of inputs shortly after a rising edge, then let them settle.
    task automatic drive(input logic mr, input logic ps, input logic as, input logic rd,
                         input logic rw, input logic j, input logic [2:0] ac,
                         input logic [31:0] ins, input logic [31:0] rdat);
        @(posedge clk);
        #2;
        memtoreg = mr; pcsrc = ps; alusrc = as; regdst = rd;
        regwrite = rw; jump = j; alucontrol = ac; instr = ins; readdata = rdat;
        #1;
    endtask

    initial begin
        reset = 1; memtoreg = 0; pcsrc = 0; alusrc = 0; regdst = 0;
        regwrite = 0; jump = 0; alucontrol = 3'b000; instr = 0; readdata = 0;

        // Reset for one edge, then sequential PC stepping.
        @(posedge clk); #2; reset = 0; #1;
        check("reset_pc", pc, 32'h0);
        check("reset_rd0", writedata, 32'h0);
        drive(0,0,0,0,0,0,3'b000, 32'h0, 0); check("pc_step4", pc, 32'h4);
        drive(0,0,0,0,0,0,3'b000, 32'h0, 0); check("pc_step8", pc, 32'h8);

        // Immediates.
        drive(0,0,1,0,1,0,3'b010, itype(0,1,16'd5), 0);      check("addi5", aluout, 32'd5);
        drive(0,0,1,0,1,0,3'b010, itype(0,2,16'd3), 0);      check("addi3", aluout, 32'd3);
        drive(0,0,1,0,0,0,3'b010, itype(0,0,16'hFFFF), 0);   check("addi_neg", aluout, 32'hFFFF_FFFF);

        // R-type operations.
        drive(0,0,0,1,1,0,3'b010, rtype(1,2,3), 0);
        check("add", aluout, 32'd8); check("add_zero", {31'd0, zero}, 32'd0);
        drive(0,0,0,1,1,0,3'b110, rtype(1,2,4), 0);          check("sub", aluout, 32'd2);
        drive(0,0,0,1,0,0,3'b110, rtype(1,1,0), 0);          check("sub_zero", {31'd0, zero}, 32'd1);
        drive(0,0,0,1,1,0,3'b111, rtype(2,1,5), 0);          check("slt", aluout, 32'd1);
        drive(0,0,0,1,0,0,3'b000, rtype(1,2,0), 0);          check("and", aluout, 32'd1);
        drive(0,0,0,1,0,0,3'b001, rtype(1,2,0), 0);          check("or", aluout, 32'd7);
        drive(0,0,0,1,1,0,3'b010, rtype(1,2,0), 0);          check("wr_r0_alu", aluout, 32'd8);
        drive(0,0,0,1,0,0,3'b001, rtype(0,0,0), 0);
        check("r0_stays0", aluout, 32'd0); check("r0_wd", writedata, 32'd0);
        drive(0,0,0,1,0,0,3'b010, rtype(3,4,0), 0);
        check("r3_r4", aluout, 32'd10); check("r4_wd", writedata, 32'd2);

        // Load into $6, then read it back as store data.
        drive(1,0,1,0,1,0,3'b010, itype(1,6,16'd0), 32'hABCD_1234); check("lw_addr", aluout, 32'd5);
        drive(0,0,0,1,0,0,3'b010, rtype(0,6,0), 0);          check("lw_data", writedata, 32'hABCD_1234);

        // Jump to 0x10, branch to 0x24, jump to 0x100, then jump beats branch.
        drive(0,0,0,0,0,1,3'b000, 32'h0000_0004, 0);
        drive(0,1,0,0,0,0,3'b000, itype(0,0,16'd4), 0);      check("pc_at10", pc, 32'h10);
        drive(0,0,0,0,0,1,3'b000, 32'h0000_0040, 0);         check("branch", pc, 32'h24);
        drive(0,1,0,0,0,1,3'b000, 32'h0000_0040, 0);         check("jump", pc, 32'h100);
        drive(0,0,0,0,0,0,3'b000, 32'h0, 0);                 check("jump_prio", pc, 32'h100);

        // Reset mid-run with a pending write to $7, then every register reads zero.
        drive(0,0,1,0,1,0,3'b010, itype(0,7,16'h55), 0);
        reset = 1;
        drive(0,0,0,1,0,0,3'b001, rtype(0,0,0), 0);
        reset = 0;
        check("midreset_pc", pc, 32'h0);
        for (int r = 0; r < 32; r++) begin
            drive(0,0,0,1,0,0,3'b001, rtype(5'(r), 5'(r), 0), 0);
            check("midreset_rs", aluout, 32'd0);
            check("midreset_rt", writedata, 32'd0);
        end

        // Randomized run checked by the compare process.
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                  1'($urandom_range(0,1)), 1'($urandom_range(0,3) != 0), 1'($urandom_range(0,3) == 0),
                  3'($urandom_range(0,7)), $urandom, $urandom);
            reset = ($urandom_range(0,63) == 0);
        end
        reset = 0;
        @(posedge clk); @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-cycle MIPS-style datapath: PC register, next-PC logic, 32-entry register file, sign extension, operand muxes, ALU and write-back mux.
- All control signals come from an external controller.
- Instruction memory and data memory are external; instruction and load data arrive as inputs.
- Sits between the controller and the instruction/data memories in the single-cycle CPU top level.

Parameters:
- n, 32, datapath width (PC, registers, ALU, memory data). Instruction field positions assume n=32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memtoreg  input  1  write-back select: 1=readdata, 0=aluout.
- pcsrc  input  1  1=take branch target.
- alusrc  input  1  ALU B operand: 1=sign-extended immediate, 0=register rt.
- regdst  input  1  destination register: 1=rd (instr[15:11]), 0=rt (instr[20:16]).
- regwrite  input  1  register file write enable.
- jump  input  1  1=jump target overrides branch/sequential PC.
- alucontrol  input  3  ALU operation select.
- zero  output  1  1 when aluout == 0.
- pc  output  n  current program counter.
- instr  input  n  current instruction.
- aluout  output  n  ALU result; also the data memory address.
- writedata  output  n  register rt read data (store data).
- readdata  input  n  data memory read data.

Behaviour:
- Instruction fields:
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].
  - imm = instr[15:0]; signimm = imm sign-extended to n bits.
- Register file:
  - 32 x n.
  - Two combinational read ports: rd1 = reg[rs], rd2 = reg[rt].
  - One write port, written on rising clk when regwrite=1.
  - Register 0 always reads 0; writes to it are ignored.
  - Write address = regdst ? rd : rt.
  - Write data (result) = memtoreg ? readdata : aluout.
  - A read of a register being written in the same cycle returns the old value; the new value is visible after the edge.
- ALU:
  - srcA = rd1; srcB = alusrc ? signimm : rd2.
  - alucontrol encoding:
    - 000 AND
    - 001 OR
    - 010 ADD
    - 110 SUB (A-B)
    - 111 SLT (signed A<B gives 1, else 0)
    - 011, 100, 101 produce 0
  - Add/sub wrap modulo 2^n; no overflow flag.
  - Outputs aluout and zero are combinational.
- writedata = rd2, combinational.
- Next PC:
  - pcplus4 = pc + 4.
  - pcbranch = pcplus4 + (signimm << 2).
  - pcnextbr = pcsrc ? pcbranch : pcplus4.
  - pcjump = {pcplus4[31:28], instr[25:0], 2'b00}.
  - pcnext = jump ? pcjump : pcnextbr; jump has priority over pcsrc.
  - pc <= pcnext on each rising edge when reset=0.
- Reset:
  - On a rising edge with reset=1: pc <= 0 and all 32 registers <= 0.
  - Register writes are suppressed during reset.
  - Reset mid-operation discards any pending write in that cycle.
  - Combinational outputs follow current state, so after the reset edge aluout/writedata derive from zeroed registers.
- Latency: single cycle.
  - A result appears on aluout in the same cycle the instruction is presented.
  - It is committed to the register file at the next rising edge.
  - No handshakes.

Test Plan:
- Reset held 1 cycle: pc=0 and reg reads 0. Release with pcsrc=jump=0: pc steps 0, 4, 8, ... once per clock.
- Immediates:
  - ADDI $1 = $0+5 (regdst=0, alusrc=1, regwrite=1, alucontrol=010): aluout=5 that cycle; $1=5 after the edge.
  - ADDI $2 = $0+3: $2=3.
  - ADDI with imm 0xFFFF: aluout = 0xFFFFFFFF on $0.
- R-type ALU ops:
  - ADD $3=$1+$2 (regdst=1, alusrc=0): aluout=8, zero=0.
  - SUB $4=$1-$2 (110): aluout=2.
  - SUB $1-$1: zero=1.
  - SLT $2,$1: 1.
  - AND: 1; OR: 7.
  - Write to $0 leaves $0=0.
- Load: memtoreg=1, readdata=0xABCD1234, lw $6,0($1). Then present an instruction with rt=6: writedata=0xABCD1234.
- Branch/jump:
  - At pc=0x10, pcsrc=1, imm=4: next pc=0x24.
  - jump=1, instr[25:0]=0x40: next pc=0x100.
  - jump=1 and pcsrc=1 together: jump target wins.
- Reset mid-run: after $1..$6 are written, assert reset one cycle: pc=0, all registers read 0, no write occurs that cycle.
